// File: rtl/rv_mem_wait.sv
// rv_mem_wait: single-port word memory with a fixed number of wait states and a one-cycle ready pulse.
module rv_mem_wait #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, rdata_q;
  logic [31:0] mem [DEPTH];
  logic bad, acc;
  // Misaligned or beyond the array: rejected without touching memory.
  assign bad = (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0);
  assign acc = (state_q == WAIT) && (cnt_q == '0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req) begin
        we_d    = we;
        idx_d   = addr[AW+1:2];
        wdata_d = wdata;
        err_d   = bad;
        cnt_d   = CNT_W'(LATENCY);
        state_d = bad ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = acc ? cnt_q : cnt_q - CNT_W'(1);
        state_d = acc ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  // The access commits on the edge that enters RESP; reset suppresses a pending store.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (acc) begin
      if (we_q) mem[idx_q] <= wdata_q;
      else rdata_q <= mem[idx_q];
    end
  end
  assign rdata = rdata_q;
  assign ready = (state_q == RESP);
  assign err   = (state_q == RESP) && err_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_rv_mem_wait.sv
// tb_rv_mem_wait: two instances (LATENCY=2 and LATENCY=0) checked every cycle against a schedule-based model.
module tb_rv_mem_wait;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req [2];
  logic we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic ready [2];
  logic err [2];
  logic busy [2];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit go = 0;
  int lat_p [2] = '{2, 0};
  bit pend [2];
  int due [2];
  bit m_err [2];
  bit m_we [2];
  int m_idx [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_rd [2];
  logic [31:0] mm [2][1024];

  always #5 clk = ~clk;

  rv_mem_wait #(.DEPTH(1024), .LATENCY(2), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0])
  );
  rv_mem_wait #(.DEPTH(1024), .LATENCY(0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[u%0d] got %h expected %h at cycle %0d", nm, i, act, exp, cyc);
  endtask

  // Model: an accepted request is a scheduled ready cycle; valid accesses commit on entering it.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pend[i] = 0;
        m_rd[i] = 32'h0;
      end else if (pend[i] && cyc - 1 == due[i]) begin
        pend[i] = 0;
      end else if (pend[i]) begin
        if (!m_err[i] && cyc == due[i]) begin
          if (m_we[i]) mm[i][m_idx[i]] = m_wd[i];
          else m_rd[i] = mm[i][m_idx[i]];
        end
      end else if (req[i]) begin
        pend[i]  = 1;
        m_we[i]  = we[i];
        m_wd[i]  = wdata[i];
        m_err[i] = (addr[i] % 4 != 0) || (addr[i] >= 32'd4096);
        m_idx[i] = int'(addr[i][11:2]);
        due[i]   = m_err[i] ? cyc : cyc + 1 + lat_p[i];
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int i = 0; i < 2; i++) begin
        chk("ready", i, 32'(ready[i]), 32'(pend[i] && cyc == due[i]));
        chk("err", i, 32'(err[i]), 32'(pend[i] && cyc == due[i] && m_err[i]));
        chk("busy", i, 32'(busy[i]), 32'(pend[i]));
        chk("rdata", i, rdata[i], m_rd[i]);
      end
    end
  end

  task automatic wait_ready(input int i, output int lat, output logic e, output logic [31:0] rd);
    bit seen = 0;
    lat = -1;
    e = 1'bx;
    rd = 32'hx;
    for (int n = 1; n <= 40 && !seen; n++) begin
      if (ready[i]) begin
        seen = 1;
        lat = n;
        e = err[i];
        rd = rdata[i];
      end else @(negedge clk);
    end
  endtask

  task automatic acc(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int el, input logic ee, input bit crd, input logic [31:0] erd, input string nm);
    int lat;
    logic e;
    logic [31:0] rd;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(negedge clk);
    req[i] = 1'b0; we[i] = ~w; addr[i] = $urandom; wdata[i] = $urandom;
    wait_ready(i, lat, e, rd);
    chk({nm, "_lat"}, i, lat, el);
    chk({nm, "_err"}, i, 32'(e), 32'(ee));
    if (crd) chk({nm, "_rdata"}, i, rd, erd);
  endtask

  initial begin
    int pulses, pulse_k;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    go = 1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(ready[i]), 0);
      chk("rst_busy", i, 32'(busy[i]), 0);
      chk("rst_err", i, 32'(err[i]), 0);
      chk("rst_rdata", i, rdata[i], 0);
    end
    acc(0, 1, 32'h10, 32'hDEADBEEF, 4, 0, 1, 32'h0, "st10");
    acc(0, 0, 32'h10, 32'h0, 4, 0, 1, 32'hDEADBEEF, "ld10");
    acc(0, 1, 32'h4, 32'hA5A50004, 4, 0, 0, 32'h0, "st4");
    acc(0, 0, 32'h4, 32'h0, 4, 0, 1, 32'hA5A50004, "ld4");
    acc(0, 0, 32'h10, 32'h0, 4, 0, 1, 32'hDEADBEEF, "ld10b");
    acc(0, 0, 32'h6, 32'h0, 1, 1, 1, 32'hDEADBEEF, "mis6");
    acc(0, 1, 32'h6, 32'h66666666, 1, 1, 1, 32'hDEADBEEF, "mis6st");
    acc(0, 0, 32'h4, 32'h0, 4, 0, 1, 32'hA5A50004, "ld4b");
    acc(0, 1, 32'h0, 32'h11110000, 4, 0, 0, 32'h0, "st0");
    acc(0, 1, 32'h1000, 32'h00000BAD, 1, 1, 0, 32'h0, "oor");
    acc(0, 0, 32'h0, 32'h0, 4, 0, 1, 32'h11110000, "ld0");
    acc(0, 1, 32'hFFC, 32'h0FFC0FFC, 4, 0, 0, 32'h0, "stlast");
    acc(0, 0, 32'hFFC, 32'h0, 4, 0, 1, 32'h0FFC0FFC, "ldlast");
    acc(0, 1, 32'h34, 32'h34343434, 4, 0, 0, 32'h0, "st34");
    @(negedge clk);
    req[0] = 1; we[0] = 1; addr[0] = 32'h30; wdata[0] = 32'hCAFE0030;
    pulses = 0;
    pulse_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready[0]) begin
        pulses++;
        pulse_k = k;
      end
      req[0] = (k == 1 || k == 3 || k == 4);
      addr[0] = 32'h34;
      wdata[0] = 32'h0BAD0000 + 32'(k);
    end
    chk("tog_pulses", 0, pulses, 1);
    chk("tog_when", 0, pulse_k, 4);
    acc(0, 0, 32'h30, 32'h0, 4, 0, 1, 32'hCAFE0030, "ld30");
    acc(0, 0, 32'h34, 32'h0, 4, 0, 1, 32'h34343434, "ld34");
    acc(1, 1, 32'h0, 32'h12345678, 2, 0, 0, 32'h0, "l0st0");
    acc(1, 0, 32'h0, 32'h0, 2, 0, 1, 32'h12345678, "l0ld0");
    acc(1, 0, 32'h2, 32'h0, 1, 1, 1, 32'h12345678, "l0mis");
    acc(1, 0, 32'h2000, 32'h0, 1, 1, 1, 32'h12345678, "l0oor");
    acc(0, 1, 32'h20, 32'h20202020, 4, 0, 0, 32'h0, "st20");
    @(negedge clk);
    req[0] = 1; we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'hFFFF0000;
    @(negedge clk);
    req[0] = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_busy", 0, 32'(busy[0]), 0);
    chk("mid_ready", 0, 32'(ready[0]), 0);
    chk("mid_err", 0, 32'(err[0]), 0);
    chk("mid_rdata", 0, rdata[0], 0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("mid_noready", 0, pulses, 0);
    acc(0, 0, 32'h20, 32'h0, 4, 0, 1, 32'h20202020, "ld20");
    acc(1, 0, 32'h0, 32'h0, 2, 0, 1, 32'h12345678, "l0ld0b");
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/rv_mem_wait.md
Name: rv_mem_wait

Overview:
- Unified instruction/data memory for the multicycle RISC-V core, with a configurable wait-state count.
- Sits directly downstream of the control unit's memory strobe and the datapath address/store-data outputs.
- Accepts one word request at a time and returns a one-cycle ready pulse, registered read data and an error flag.
- Lets the control FSM hold its FETCH/LW_MEM/SW_MEM states until the access completes.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, extra wait cycles per access (0..15).
- CNT_W, 4, width of the wait counter; must satisfy LATENCY < 2**CNT_W.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store word, 0 = load word; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- rdata  out  32  registered load data; holds its value between completions.
- ready  out  1  single-cycle completion pulse.
- err  out  1  valid only while ready=1; access rejected.
- busy  out  1  request in flight; high in WAIT and RESP.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, ready=0, err=0, busy=0, rdata=32'h0, counter=0. Memory array is not reset.
- Reset mid-operation: any captured request is discarded. A pending store is never written. No ready pulse follows the reset.
- State machine: IDLE, WAIT, RESP.
- IDLE, req=1 at the edge ending cycle T: capture we, addr, wdata.
  - If addr[1:0]!=0 or addr>=DEPTH*4: go to RESP with error set.
  - Otherwise go to WAIT with counter=LATENCY.
  - IDLE with req=0 stays in IDLE.
- WAIT, counter!=0: decrement the counter and stay in WAIT.
- WAIT, counter==0: perform the access at this edge and go to RESP.
  - Store: write mem[addr[log2(DEPTH)+1:2]] <= wdata; rdata is unchanged.
  - Load: rdata <= mem[index].
- RESP: ready=1; err=1 if and only if the request was rejected; go to IDLE on the next edge unconditionally.
- Rejected request: no memory access, rdata unchanged.
- Latency for a valid access accepted at edge T: ready is high in cycle T+2+LATENCY. With LATENCY=0, ready is high in cycle T+2.
- Latency for an error: ready is high in cycle T+1.
- req while busy=1, including during the RESP cycle, is ignored and not queued. The requester must re-assert req in IDLE.
- Outputs:
  - busy=1 in WAIT and RESP, 0 in IDLE.
  - ready and err are registered (decoded from state/flag flops), never combinational from req.
- Read-after-write: the store commits at the edge entering RESP, so any later accepted load returns the new data.
- Address wrap: none. Out-of-range addresses error and do not alias.
- we, addr and wdata may change freely after acceptance; only the captured copies are used.

Test Plan:
- LATENCY=2: store 0xDEADBEEF to 0x10 (req pulse at T), then load 0x10 → ready in T+4 with err=0; the load's ready carries rdata=0xDEADBEEF; busy high T+1..T+4.
- LATENCY=0: load from 0x0 after storing 0x12345678 → ready exactly 2 cycles after acceptance, rdata=0x12345678.
- Misaligned load at 0x6 → ready with err=1 one cycle after acceptance; rdata keeps its prior value; memory unchanged (a follow-up load of 0x4 returns its old word).
- Out-of-range store to DEPTH*4 (0x1000) → err=1; a subsequent load of 0x0 is unchanged (no aliasing).
- Store accepted, then req toggled with a different addr/wdata every cycle while busy → exactly one ready pulse; only the first store lands.
- Store to 0x20 accepted, rst asserted for 1 cycle in WAIT → no ready; all outputs return to reset values next cycle; a load of 0x20 returns the old contents.
